// File: rtl/bp_perf_monitor.sv
// Multi-channel branch-prediction performance monitor: per-channel saturating
// event counters over a programmable window, with start/stop/clear and registered readout.
module bp_perf_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] instr_vld_i,
    input  logic [NUM_CH-1:0] br_instr_i,
    input  logic [NUM_CH-1:0] br_miss_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              clear_i,
    input  logic [CNT_W-1:0]  window_len_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    input  logic [1:0]        rd_sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic [NUM_CH-1:0] anom_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  win_q;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  instr_cnt [NUM_CH];
    logic [CNT_W-1:0]  br_cnt    [NUM_CH];
    logic [CNT_W-1:0]  miss_cnt  [NUM_CH];

    logic              run_c;
    logic              start_go_c;
    logic              zero_c;
    logic              cyc_sat_c;
    logic              win_end_c;
    logic              finish_c;
    logic [NUM_CH-1:0] miss_inc_c;
    logic [NUM_CH-1:0] anom_c;
    logic [NUM_CH-1:0] ch_sat_c;
    logic [CNT_W-1:0]  rd_mux_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(inc);
    endfunction

    assign run_c      = (state == RUN);
    assign start_go_c = start_i && !run_c;
    assign zero_c     = clear_i || start_go_c;
    // The window-1 cycle is the last counted one, so the final cycle count equals the window.
    assign win_end_c  = (win_q != '0) && (cyc_cnt == win_q - CNT_ONE);
    assign cyc_sat_c  = (cyc_cnt == CNT_LAST);
    assign finish_c   = stop_i || win_end_c || cyc_sat_c;
    assign miss_inc_c = br_miss_i & br_instr_i;
    assign anom_c     = br_miss_i & ~br_instr_i;

    // A channel saturates when any of its counters reaches the top value this cycle.
    always_comb begin
        ch_sat_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sat_c[c] = (instr_vld_i[c] && (instr_cnt[c] >= CNT_LAST))
                       || (br_instr_i[c]  && (br_cnt[c]    >= CNT_LAST))
                       || (miss_inc_c[c]  && (miss_cnt[c]  >= CNT_LAST));
        end
    end

    // Control state, cycle counter and sticky flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            win_q   <= '0;
            cyc_cnt <= '0;
            ovf_o   <= '0;
            anom_o  <= '0;
        end else begin
            done_o <= 1'b0;
            if (clear_i) begin
                state   <= IDLE;
                busy_o  <= 1'b0;
                cyc_cnt <= '0;
                ovf_o   <= '0;
                anom_o  <= '0;
            end else if (start_go_c) begin
                state   <= RUN;
                busy_o  <= 1'b1;
                win_q   <= window_len_i;
                cyc_cnt <= '0;
                ovf_o   <= '0;
                anom_o  <= '0;
            end else if (run_c) begin
                cyc_cnt <= cyc_cnt + CNT_ONE;
                ovf_o   <= cyc_sat_c ? '1 : (ovf_o | ch_sat_c);
                anom_o  <= anom_o | anom_c;
                if (finish_c) begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end

    // Per-channel event counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                instr_cnt[c] <= '0;
                br_cnt[c]    <= '0;
                miss_cnt[c]  <= '0;
            end
        end else if (zero_c) begin
            for (int c = 0; c < NUM_CH; c++) begin
                instr_cnt[c] <= '0;
                br_cnt[c]    <= '0;
                miss_cnt[c]  <= '0;
            end
        end else if (run_c) begin
            for (int c = 0; c < NUM_CH; c++) begin
                instr_cnt[c] <= sat_inc(instr_cnt[c], instr_vld_i[c]);
                br_cnt[c]    <= sat_inc(br_cnt[c], br_instr_i[c]);
                miss_cnt[c]  <= sat_inc(miss_cnt[c], miss_inc_c[c]);
            end
        end
    end

    // Readout mux; an out-of-range channel reads as zero for every select.
    always_comb begin
        rd_mux_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == CH_W'(c)) begin
                case (rd_sel_i)
                    2'd0:    rd_mux_c = instr_cnt[c];
                    2'd1:    rd_mux_c = br_cnt[c];
                    2'd2:    rd_mux_c = miss_cnt[c];
                    default: rd_mux_c = cyc_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_data_o <= '0;
        else         rd_data_o <= rd_mux_c;
    end

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Bench for bp_perf_monitor (4 channels, 8-bit counters): directed scenarios plus
// random traffic, all checked every cycle against an arithmetic reference model.
module tb_bp_perf_monitor;

    localparam int NCH  = 4;
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] instr_vld, br_instr, br_miss;
    logic       start, stop, clear;
    logic [7:0] window_len;
    logic [2:0] rd_ch;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       busy, done;
    logic [3:0] ovf, anom;

    bp_perf_monitor #(.NUM_CH(4), .CNT_W(8), .CH_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_vld_i(instr_vld), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .start_i(start), .stop_i(stop), .clear_i(clear),
        .window_len_i(window_len), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
        .rd_data_o(rd_data), .busy_o(busy), .done_o(done),
        .ovf_o(ovf), .anom_o(anom)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen;

    // Reference model: plain integer counts and a run/idle/done mode number.
    int       m_mode;
    int       m_cyc, m_win;
    int       m_instr [NCH];
    int       m_br    [NCH];
    int       m_miss  [NCH];
    bit [3:0] m_ovf, m_anom;
    bit       m_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_zero();
        for (int c = 0; c < NCH; c++) begin
            m_instr[c] = 0; m_br[c] = 0; m_miss[c] = 0;
        end
        m_cyc = 0; m_ovf = '0; m_anom = '0;
    endfunction

    function automatic void model_reset();
        model_zero();
        m_mode = 0; m_win = 0; m_done = 1'b0;
    endfunction

    function automatic int sat_add(input int v, input bit inc, input int c);
        int r;
        r = (inc && v < MAXV) ? v + 1 : v;
        if (inc && r == MAXV) m_ovf[c] = 1'b1;
        return r;
    endfunction

    // One clock edge of the monitor, from the inputs applied during that cycle.
    function automatic void model_edge();
        bit fin;
        m_done = 1'b0;
        if (clear) begin
            model_zero(); m_mode = 0;
        end else if (m_mode != 1 && start) begin
            model_zero(); m_win = int'(window_len); m_mode = 1;
        end else if (m_mode == 1) begin
            for (int c = 0; c < NCH; c++) begin
                m_instr[c] = sat_add(m_instr[c], instr_vld[c], c);
                m_br[c]    = sat_add(m_br[c], br_instr[c], c);
                m_miss[c]  = sat_add(m_miss[c], br_miss[c] & br_instr[c], c);
                if (br_miss[c] && !br_instr[c]) m_anom[c] = 1'b1;
            end
            m_cyc++;
            fin = stop || (m_win != 0 && m_cyc == m_win);
            if (m_cyc == MAXV) begin
                m_ovf = '1; fin = 1'b1;
            end
            if (fin) begin
                m_mode = 2; m_done = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] model_read(input int ch, input int sel);
        if (ch >= NCH) return 8'd0;
        case (sel)
            0:       return 8'(m_instr[ch]);
            1:       return 8'(m_br[ch]);
            2:       return 8'(m_miss[ch]);
            default: return 8'(m_cyc);
        endcase
    endfunction

    task automatic tick();
        logic [7:0] exp_rd;
        exp_rd = model_read(int'(rd_ch), int'(rd_sel));
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_data", rd_data, exp_rd);
        chk("busy", busy, m_mode == 1);
        chk("done", done, m_done);
        chk("ovf", ovf, m_ovf);
        chk("anom", anom, m_anom);
        if (done === 1'b1) done_seen++;
    endtask

    task automatic idle_in();
        instr_vld = '0; br_instr = '0; br_miss = '0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic rd(input int ch, input int sel, input int exp, input string tag);
        idle_in();
        rd_ch = 3'(ch); rd_sel = 2'(sel);
        tick();
        chk(tag, rd_data, 64'(exp));
    endtask

    task automatic do_start(input int win);
        idle_in();
        window_len = 8'(win); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int done_at;
        rst_n = 1'b0; idle_in(); window_len = '0; rd_ch = '0; rd_sel = '0;
        model_reset();
        #12;
        chk("reset_busy", busy, 0); chk("reset_done", done, 0);
        chk("reset_rd", rd_data, 0); chk("reset_ovf", ovf, 0); chk("reset_anom", anom, 0);
        rst_n = 1'b1;

        // Window of 10: ch0 instr every cycle, branch every 2nd, two misses; start-cycle events dropped
        done_seen = 0; done_at = -1;
        idle_in(); window_len = 8'd10; start = 1'b1; instr_vld = 4'b0001; br_instr = 4'b0001;
        tick();
        for (int n = 0; n < 13; n++) begin
            idle_in();
            instr_vld[0] = 1'b1;
            br_instr[0]  = (n % 2 == 0);
            br_miss[0]   = (n == 0 || n == 4);
            tick();
            if (done === 1'b1 && done_at < 0) done_at = n + 1;
        end
        chk("win_done_edges_after_start", done_at, 10);
        chk("win_done_pulses", done_seen, 1);
        rd(0, 3, 10, "win_cycles");
        rd(0, 0, 10, "win_ch0_instr");
        rd(0, 1, 5, "win_ch0_br");
        rd(0, 2, 2, "win_ch0_miss");
        for (int c = 1; c < NCH; c++)
            for (int s = 0; s < 3; s++) rd(c, s, 0, "win_other_ch");

        // Early stop on the 7th RUN cycle, unbounded window
        done_seen = 0;
        do_start(0);
        for (int n = 0; n < 7; n++) begin
            idle_in(); instr_vld[2] = 1'b1; stop = (n == 6);
            tick();
        end
        chk("stop_busy_low", busy, 0);
        chk("stop_done_now", done, 1);
        for (int n = 0; n < 3; n++) begin idle_in(); stop = 1'b1; tick(); end
        chk("stop_done_pulses", done_seen, 1);
        rd(2, 0, 7, "stop_ch2_instr");
        rd(2, 3, 7, "stop_cycles");

        // Anomaly on ch3, then start requests during RUN are ignored
        do_start(0);
        idle_in(); br_miss[3] = 1'b1;
        tick();
        chk("anom_set", anom, 4'b1000);
        for (int n = 0; n < 3; n++) begin
            idle_in(); start = 1'b1; window_len = 8'd2; instr_vld[0] = 1'b1;
            tick();
        end
        chk("restart_ignored_busy", busy, 1);
        idle_in(); stop = 1'b1;
        tick();
        rd(3, 2, 0, "anom_ch3_miss");
        rd(0, 0, 3, "restart_ignored_instr");
        rd(0, 3, 5, "restart_ignored_cycles");
        do_start(0);
        chk("anom_cleared_by_start", anom, 0);

        // Clear + stop + start in one RUN cycle: clear wins
        for (int n = 0; n < 3; n++) begin
            idle_in(); instr_vld = '1; br_instr = '1; br_miss = '1; tick();
        end
        done_seen = 0;
        idle_in(); clear = 1'b1; stop = 1'b1; start = 1'b1; instr_vld = '1;
        tick();
        chk("prio_busy", busy, 0);
        chk("prio_done", done_seen, 0);
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++) rd(c, s, 0, "prio_zero_read");

        // Out-of-range channel reads zero while real counters are nonzero
        do_start(0);
        for (int n = 0; n < 4; n++) begin idle_in(); instr_vld = '1; tick(); end
        idle_in(); stop = 1'b1; tick();
        rd(4, 0, 0, "oor_instr");
        rd(4, 3, 0, "oor_cycles");
        rd(0, 0, 4, "inrange_instr");

        // Saturation: ch1 instr every cycle for 300 cycles, cycle counter forces DONE
        done_seen = 0;
        do_start(0);
        for (int n = 0; n < 300; n++) begin idle_in(); instr_vld[1] = 1'b1; tick(); end
        chk("sat_done_pulses", done_seen, 1);
        chk("sat_ovf", ovf, 4'b1111);
        rd(1, 0, 255, "sat_ch1_instr");
        rd(1, 3, 255, "sat_cycles");
        rd(0, 0, 0, "sat_ch0_instr");

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            instr_vld  = 4'($urandom);
            br_instr   = 4'($urandom);
            br_miss    = 4'($urandom) & 4'($urandom);
            start      = ($urandom_range(0, 15) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            clear      = ($urandom_range(0, 59) == 0);
            window_len = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            rd_ch      = 3'($urandom_range(0, 4));
            rd_sel     = 2'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of a run
        do_start(0);
        for (int n = 0; n < 4; n++) begin
            idle_in(); instr_vld = '1; br_miss[0] = 1'b1; tick();
        end
        chk("pre_reset_anom", anom, 4'b0001);
        done_seen = 0;
        rd_ch = 3'd0; rd_sel = 2'd0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_rd", rd_data, 0);
        chk("arst_ovf", ovf, 0); chk("arst_anom", anom, 0); chk("arst_done", done, 0);
        model_reset();
        #3 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin idle_in(); instr_vld = '1; tick(); end
        chk("post_reset_no_done", done_seen, 0);
        rd(0, 3, 0, "post_reset_cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
